// File: rtl/l1_refill_ctrl.sv
// L1 miss sequencer: optional dirty-victim writeback to L2, then line refill into the L1 data RAM plus tag install.
// One miss in flight; L2 requests are held until req_rdy; refill beats may arrive with gaps, writeback beats do not.
module l1_refill_ctrl #(
    parameter int LINE_WORDS    = 4,
    parameter int L2_ADDR_WIDTH = 16,
    parameter int L2_DATA_WIDTH = 32,
    parameter int L2_CMND_WIDTH = 2,
    parameter int L2_SIZE_WIDTH = 3,
    localparam int IDX_W        = $clog2(LINE_WORDS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         miss_req,
    input  logic [L2_ADDR_WIDTH-1:0]     miss_addr,
    input  logic                         evict_dirty,
    input  logic [L2_ADDR_WIDTH-1:0]     evict_addr,
    output logic                         miss_ack,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic                         ram_rd_en,
    output logic [IDX_W-1:0]             ram_rd_idx,
    input  logic [L2_DATA_WIDTH-1:0]     ram_rd_data,
    output logic                         ram_wr_en,
    output logic [IDX_W-1:0]             ram_wr_idx,
    output logic [L2_DATA_WIDTH-1:0]     ram_wr_data,
    output logic                         tag_upd,
    output logic                         req_val,
    input  logic                         req_rdy,
    output logic                         req_nc,
    output logic [L2_CMND_WIDTH-1:0]     req_cmd,
    output logic [L2_SIZE_WIDTH-1:0]     req_size,
    output logic [L2_ADDR_WIDTH-1:0]     req_addr,
    output logic                         req_wdata_val,
    output logic [L2_DATA_WIDTH-1:0]     req_wdata,
    output logic [L2_DATA_WIDTH/8-1:0]   req_wstrb,
    input  logic                         resp_val,
    input  logic                         resp_err,
    input  logic                         resp_rdata_val,
    input  logic [L2_DATA_WIDTH-1:0]     resp_rdata
);

    localparam int OFF_W = $clog2(LINE_WORDS * L2_DATA_WIDTH / 8);
    localparam logic [L2_SIZE_WIDTH-1:0] LINE_SIZE = L2_SIZE_WIDTH'(OFF_W);
    localparam logic [L2_CMND_WIDTH-1:0] CMD_RD    = '0;
    localparam logic [L2_CMND_WIDTH-1:0] CMD_WR    = L2_CMND_WIDTH'(1);
    localparam logic [IDX_W:0]           CNT_LINE  = (IDX_W+1)'(LINE_WORDS);
    localparam logic [IDX_W:0]           CNT_LAST  = (IDX_W+1)'(LINE_WORDS - 1);
    localparam logic [L2_ADDR_WIDTH-1:0] LINE_MASK = ~(L2_ADDR_WIDTH'((1 << OFF_W) - 1));

    typedef enum logic [2:0] {
        S_IDLE, S_WB_REQ, S_WB_DATA, S_WB_RESP, S_RF_REQ, S_RF_DATA, S_DONE
    } state_t;

    state_t                     state_q;
    logic [IDX_W:0]             cnt_q;
    logic [L2_ADDR_WIDTH-1:0]   miss_addr_q;
    logic [L2_ADDR_WIDTH-1:0]   evict_addr_q;
    logic                       err_q;
    logic                       wb_first_q;

    logic                       rf_beat;
    logic [IDX_W:0]             beats_d;

    // Beats past the line size are dropped, so cnt_q saturates at LINE_WORDS.
    assign rf_beat = (state_q == S_RF_DATA) && resp_rdata_val && (cnt_q < CNT_LINE);
    assign beats_d = cnt_q + {{IDX_W{1'b0}}, rf_beat};

    assign miss_ack = (state_q == S_IDLE) && miss_req;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign err      = done && err_q;

    // Victim word k+1 is fetched while beat k goes out, so L2 sees a gapless burst.
    assign ram_rd_en  = ((state_q == S_WB_REQ) && wb_first_q) ||
                        ((state_q == S_WB_DATA) && (cnt_q < CNT_LAST));
    assign ram_rd_idx = (ram_rd_en && (state_q == S_WB_DATA)) ?
                        (cnt_q[IDX_W-1:0] + IDX_W'(1)) : '0;

    assign ram_wr_en   = rf_beat;
    assign ram_wr_idx  = rf_beat ? cnt_q[IDX_W-1:0] : '0;
    assign ram_wr_data = rf_beat ? resp_rdata : '0;
    assign tag_upd     = (state_q == S_RF_DATA) && resp_val && !resp_err && (beats_d == CNT_LINE);

    assign req_val  = (state_q == S_WB_REQ) || (state_q == S_RF_REQ);
    assign req_nc   = 1'b0;
    assign req_cmd  = (state_q == S_WB_REQ) ? CMD_WR : CMD_RD;
    assign req_size = req_val ? LINE_SIZE : '0;
    assign req_addr = (state_q == S_WB_REQ) ? evict_addr_q :
                      (state_q == S_RF_REQ) ? miss_addr_q  : '0;

    assign req_wdata_val = (state_q == S_WB_DATA);
    assign req_wdata     = req_wdata_val ? ram_rd_data : '0;
    assign req_wstrb     = req_wdata_val ? '1 : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            miss_addr_q  <= '0;
            evict_addr_q <= '0;
            err_q        <= 1'b0;
            wb_first_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (miss_req) begin
                        miss_addr_q  <= miss_addr & LINE_MASK;
                        evict_addr_q <= evict_addr & LINE_MASK;
                        err_q        <= 1'b0;
                        cnt_q        <= '0;
                        wb_first_q   <= evict_dirty;
                        state_q      <= evict_dirty ? S_WB_REQ : S_RF_REQ;
                    end
                end
                S_WB_REQ: begin
                    wb_first_q <= 1'b0;
                    if (req_rdy) begin
                        cnt_q   <= '0;
                        state_q <= S_WB_DATA;
                    end
                end
                S_WB_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_WB_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WB_RESP: begin
                    if (resp_val) begin
                        if (resp_err) begin
                            err_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_RF_REQ;
                        end
                    end
                end
                S_RF_REQ: begin
                    if (req_rdy) begin
                        cnt_q   <= '0;
                        state_q <= S_RF_DATA;
                    end
                end
                S_RF_DATA: begin
                    cnt_q <= beats_d;
                    if (resp_val) begin
                        err_q   <= resp_err || (beats_d != CNT_LINE);
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Bench for l1_refill_ctrl: plays the L2 port and the victim RAM, compares each miss against a line-level model.
module tb_l1_refill_ctrl;
    localparam int LW = 4, AW = 16, DW = 32, CW = 2, SW = 3, IW = 2;
    localparam int LINE_BYTES = LW * DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic miss_req = 0, evict_dirty = 0;
    logic [AW-1:0] miss_addr = '0, evict_addr = '0;
    logic miss_ack, busy, done, err;
    logic ram_rd_en, ram_wr_en, tag_upd;
    logic [IW-1:0] ram_rd_idx, ram_wr_idx;
    logic [DW-1:0] ram_rd_data = '0, ram_wr_data;
    logic req_val, req_rdy = 0, req_nc, req_wdata_val;
    logic [CW-1:0] req_cmd;
    logic [SW-1:0] req_size;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW/8-1:0] req_wstrb;
    logic resp_val = 0, resp_err = 0, resp_rdata_val = 0;
    logic [DW-1:0] resp_rdata = '0;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] victim [LW];
    logic [DW-1:0] beats [LW+1];

    l1_refill_ctrl dut (
        .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
        .evict_dirty(evict_dirty), .evict_addr(evict_addr), .miss_ack(miss_ack),
        .busy(busy), .done(done), .err(err), .ram_rd_en(ram_rd_en), .ram_rd_idx(ram_rd_idx),
        .ram_rd_data(ram_rd_data), .ram_wr_en(ram_wr_en), .ram_wr_idx(ram_wr_idx),
        .ram_wr_data(ram_wr_data), .tag_upd(tag_upd), .req_val(req_val), .req_rdy(req_rdy),
        .req_nc(req_nc), .req_cmd(req_cmd), .req_size(req_size), .req_addr(req_addr),
        .req_wdata_val(req_wdata_val), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_val(resp_val), .resp_err(resp_err), .resp_rdata_val(resp_rdata_val),
        .resp_rdata(resp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            dirty;
        logic [AW-1:0] maddr;
        logic [AW-1:0] eaddr;
        int            rdy_dly;
        bit            wb_err;
        int            nb;
        int            gap;
        bit            resp_same;
        bit            rf_err;
        bit            hold;
        bit            lat;
        bit            exp_err;
        int            exp_nwr;
        bit            exp_tag;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit dirty, logic [AW-1:0] maddr, logic [AW-1:0] eaddr, int dly,
                                bit wb_err, int nb, int gap, bit same, bit rf_err, bit hold,
                                bit lat, bit e_err, int e_nwr, bit e_tag);
        vec_t v;
        v.dirty = dirty; v.maddr = maddr; v.eaddr = eaddr; v.rdy_dly = dly; v.wb_err = wb_err;
        v.nb = nb; v.gap = gap; v.resp_same = same; v.rf_err = rf_err; v.hold = hold; v.lat = lat;
        v.exp_err = e_err; v.exp_nwr = e_nwr; v.exp_tag = e_tag;
        return v;
    endfunction

    // Line-level outcome: a failed writeback skips the refill; otherwise the line is good
    // only if every word arrived before a clean response.
    function automatic vec_t model(vec_t v);
        vec_t r = v;
        if (v.dirty && v.wb_err) begin
            r.exp_err = 1; r.exp_nwr = 0; r.exp_tag = 0;
        end else begin
            r.exp_nwr = (v.nb < LW) ? v.nb : LW;
            r.exp_err = v.rf_err || (v.nb < LW);
            r.exp_tag = !r.exp_err;
        end
        return r;
    endfunction

    function automatic logic [AW-1:0] line_of(logic [AW-1:0] a);
        return AW'((int'(a) / LINE_BYTES) * LINE_BYTES);
    endfunction

    task automatic quiet();
        miss_req = 0; req_rdy = 0; resp_val = 0; resp_err = 0; resp_rdata_val = 0; resp_rdata = '0;
    endtask

    task automatic pulse_rst();
        quiet();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic run_op(input vec_t v);
        int acks = 0, n_done = 0, ntag = 0, nwr = 0, nwb = 0, n_rd = 0, n_wr = 0, busy_bad = 0;
        int ack_cyc = -1, done_cyc = -1, wait_cnt = 0, rd_tick = 0, sent = 0;
        bit got_err = 0, finished = 0, drop = 0, rd_pend = 0, rd_active = 0, wb_resp_pend = 0;
        bit strb_bad = 0, nc_bad = 0, ack_next = 0, idle_busy = 0;
        logic [IW-1:0] pend_idx = '0;
        logic [IW-1:0] wr_idx [8];
        logic [DW-1:0] wr_dat [8];
        logic [DW-1:0] wb_dat [8];
        logic [AW-1:0] rd_addr = '0, wr_addr = '0;
        logic [SW-1:0] rd_size = '0, wr_size = '0;

        miss_req = 1; miss_addr = v.maddr; evict_dirty = v.dirty; evict_addr = v.eaddr;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            if (drop) begin miss_req = 0; drop = 0; end
            if (rd_pend) begin ram_rd_data = victim[pend_idx]; rd_pend = 0; end
            req_rdy = (wait_cnt >= v.rdy_dly);
            resp_val = 0; resp_err = 0; resp_rdata_val = 0; resp_rdata = '0;
            if (wb_resp_pend) begin resp_val = 1; resp_err = v.wb_err; wb_resp_pend = 0; end
            if (rd_active) begin
                rd_tick++;
                if (sent < v.nb && rd_tick == 1 + sent * (v.gap + 1)) begin
                    resp_rdata_val = 1; resp_rdata = beats[sent]; sent++;
                    if (sent == v.nb && v.resp_same) begin
                        resp_val = 1; resp_err = v.rf_err; rd_active = 0;
                    end
                end else if (sent == v.nb) begin
                    resp_val = 1; resp_err = v.rf_err; rd_active = 0;
                end
            end
            #1;
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                ack_next = miss_ack; idle_busy = busy; finished = 1;
            end else begin
                if (miss_ack) begin
                    acks++;
                    if (ack_cyc < 0) ack_cyc = cyc;
                    if (!v.hold) drop = 1;
                end
                if (ack_cyc >= 0 && cyc > ack_cyc && !busy) busy_bad++;
                if (ram_rd_en) begin rd_pend = 1; pend_idx = ram_rd_idx; end
                if (req_val) begin
                    if (req_nc) nc_bad = 1;
                    if (req_rdy) begin
                        wait_cnt = 0;
                        if (req_cmd == CW'(1)) begin
                            n_wr++; wr_addr = req_addr; wr_size = req_size;
                        end else begin
                            n_rd++; rd_addr = req_addr; rd_size = req_size;
                            rd_active = 1; rd_tick = 0;
                        end
                    end else begin
                        wait_cnt++;
                    end
                end
                if (req_wdata_val) begin
                    if (nwb < 8) wb_dat[nwb] = req_wdata;
                    if (req_wstrb != 4'hF) strb_bad = 1;
                    nwb++;
                    if (nwb == LW) wb_resp_pend = 1;
                end
                if (ram_wr_en) begin
                    if (nwr < 8) begin wr_idx[nwr] = ram_wr_idx; wr_dat[nwr] = ram_wr_data; end
                    nwr++;
                end
                if (tag_upd) ntag++;
                if (done) begin n_done++; got_err = err; done_cyc = cyc; end
            end
            @(posedge clk); #1;
        end

        check("op_finished", finished, 1);
        check("miss_ack_count", acks, 1);
        check("done_count", n_done, 1);
        check("done_err", got_err, v.exp_err);
        check("tag_upd_count", ntag, v.exp_tag);
        check("ram_wr_count", nwr, v.exp_nwr);
        for (int k = 0; k < nwr && k < v.exp_nwr && k < 8; k++) begin
            check("ram_wr_idx", wr_idx[k], k);
            check("ram_wr_data", wr_dat[k], beats[k]);
        end
        check("wr_req_count", n_wr, v.dirty);
        if (v.dirty) begin
            check("wr_req_addr", wr_addr, line_of(v.eaddr));
            check("wr_req_size", wr_size, $clog2(LINE_BYTES));
            check("wb_beat_count", nwb, LW);
            for (int k = 0; k < nwb && k < LW; k++) check("wb_beat_data", wb_dat[k], victim[k]);
            check("wb_strb_bad", strb_bad, 0);
        end
        check("rd_req_count", n_rd, (v.dirty && v.wb_err) ? 0 : 1);
        if (!(v.dirty && v.wb_err)) begin
            check("rd_req_addr", rd_addr, line_of(v.maddr));
            check("rd_req_size", rd_size, $clog2(LINE_BYTES));
        end
        check("req_nc_bad", nc_bad, 0);
        check("busy_gap", busy_bad, 0);
        check("busy_after_done", idle_busy, 0);
        check("ack_after_done", ack_next, v.hold);
        if (v.lat) check("clean_latency", done_cyc - ack_cyc, LW + 2);
        quiet();
    endtask

    initial begin
        vec_t tab [8];
        vec_t r;
        tab[0] = mk(0, 16'h1234, 16'h0000, 0, 0, 4, 0, 1, 0, 0, 1, 0, 4, 1);
        tab[1] = mk(1, 16'h2222, 16'h0040, 3, 0, 4, 0, 0, 0, 0, 0, 0, 4, 1);
        tab[2] = mk(1, 16'h3000, 16'h0045, 1, 1, 4, 0, 1, 0, 0, 0, 1, 0, 0);
        tab[3] = mk(0, 16'h4567, 16'h0000, 0, 0, 2, 2, 0, 1, 0, 0, 1, 2, 0);
        tab[4] = mk(0, 16'h5678, 16'h0000, 2, 0, 3, 1, 1, 0, 0, 0, 1, 3, 0);
        tab[5] = mk(0, 16'h6789, 16'h0000, 0, 0, 5, 0, 0, 0, 0, 0, 0, 4, 1);
        tab[6] = mk(1, 16'h789A, 16'hABCD, 0, 0, 4, 0, 1, 1, 0, 0, 1, 4, 0);
        tab[7] = mk(0, 16'h89AB, 16'h0000, 1, 0, 4, 1, 0, 0, 1, 0, 0, 4, 1);

        quiet();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        #1;
        check("reset_outputs", |{miss_ack, busy, done, err, ram_rd_en, ram_rd_idx, ram_wr_en,
              ram_wr_idx, ram_wr_data, tag_upd, req_val, req_nc, req_cmd, req_size, req_addr,
              req_wdata_val, req_wdata, req_wstrb}, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < LW; k++) victim[k] = DW'(k + 1);
            for (int k = 0; k <= LW; k++) beats[k] = DW'(32'hA + k);
            run_op(tab[i]);
            if (tab[i].hold) pulse_rst();
        end

        // Reset while the refill is mid-line: everything clears and the next miss is clean.
        miss_req = 1; miss_addr = 16'h5555; evict_dirty = 0;
        @(posedge clk); #1;
        miss_req = 0; req_rdy = 1;
        @(posedge clk); #1;
        req_rdy = 0; resp_rdata_val = 1; resp_rdata = 32'hDEAD_BEEF;
        #1;
        check("pre_reset_wr_en", ram_wr_en, 1);
        @(posedge clk); #1;
        resp_rdata_val = 0; resp_rdata = '0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        #1;
        check("midop_reset_outputs", |{miss_ack, busy, done, err, ram_rd_en, ram_rd_idx, ram_wr_en,
              ram_wr_idx, ram_wr_data, tag_upd, req_val, req_nc, req_cmd, req_size, req_addr,
              req_wdata_val, req_wdata, req_wstrb}, 0);
        @(posedge clk); #1;
        run_op(tab[0]);

        for (int i = 0; i < 24; i++) begin
            for (int k = 0; k < LW; k++) victim[k] = $urandom;
            for (int k = 0; k <= LW; k++) beats[k] = $urandom;
            r = mk($urandom_range(0, 1), AW'($urandom), AW'($urandom), $urandom_range(0, 3),
                   ($urandom_range(0, 3) == 0), $urandom_range(1, LW + 1), $urandom_range(0, 2),
                   $urandom_range(0, 1), ($urandom_range(0, 3) == 0), 0, 0, 0, 0, 0);
            run_op(model(r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
